time_dmr_end: RTL and testbench
===============================

Name: time_dmr_end

Overview:
- Back end of a time-redundant (DMR) pipeline section. Upstream sends every item twice, back to back, with the same ID.
- This block compares the two copies and forwards one result per pair. It raises needs_retry_o when the copies disagree or a copy is lost.
- It sits between the time-DMR front end (which supplies next_id_i) and the retry end stage, which turns needs_retry_o into a re-issue request.

Parameters:
- DataType, logic [15:0], payload type; compared bit-exactly.
- IDSize, 4, width of the transaction ID.
- LockTimeout, 48, cycles a half-received pair may wait for its second copy before it is aborted.
- InternalRedundancy, 0, 1 = triplicate state/counter registers with majority voting; no functional change.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- enable_i  in  1  1 = DMR checking, 0 = pass-through
- next_id_i  in  IDSize  ID the front end will issue next
- data_i  in  DataType  upstream data
- id_i  in  IDSize  upstream ID
- valid_i  in  1  upstream valid
- ready_o  out  1  upstream ready
- data_o  out  DataType  checked data
- id_o  out  IDSize  ID of the output item
- needs_retry_o  out  1  output item is untrustworthy and must be re-issued
- valid_o  out  1  downstream valid
- ready_i  in  1  downstream ready
- lock_o  out  1  a pair is partially received; front end must not reorder
- fault_detected_o  out  1  one-cycle pulse per detected fault

Behaviour:
- Reset (asynchronous): state=EMPTY, output register invalid, counter=0, all outputs 0.
- enable_i=0: purely combinational pass-through.
  - data_o=data_i, id_o=id_i, valid_o=valid_i, ready_o=ready_i.
  - needs_retry_o=0, lock_o=0, fault_detected_o=0.
  - Internal state is held at EMPTY.
- enable_i=1 uses two storage elements: a pair buffer (first copy: data, id) and an output register (data, id, retry flag, valid).
- Output handshake:
  - valid_o/data_o/id_o/needs_retry_o come directly from the output register.
  - They stay stable while valid_o & !ready_i.
  - The register clears on valid_o & ready_i unless it is reloaded in the same cycle.
  - out_free = !valid_o | ready_i.
- State EMPTY:
  - ready_o=1.
  - Handshake stores data_i/id_i in the pair buffer; go to HAVE_FIRST; counter=0.
- State HAVE_FIRST:
  - ready_o=out_free; lock_o=1.
  - On handshake, the output register loads the stored copy: data and id.
    - Copies match (id_i==stored id and data_i==stored data): needs_retry=0; go to EMPTY.
    - Data differs, IDs equal: needs_retry=1; fault pulse; go to EMPTY.
    - IDs differ: needs_retry=1; fault pulse. The incoming beat becomes the new first copy (resync after a lost/duplicated copy); stay in HAVE_FIRST with counter=0.
- Timeout (HAVE_FIRST, no handshake):
  - Counter increments each cycle.
  - If next_id_i != stored id+1 (mod 2^IDSize), the front end has moved on, so the counter jumps to LockTimeout.
  - When counter >= LockTimeout and out_free: load the stored copy with needs_retry=1; fault pulse; go to EMPTY.
  - Until out_free, the block waits (lock_o stays 1).
- Latency: the result appears 1 cycle after the second copy's handshake.
- Throughput: one output per 2 input beats; a new first copy is accepted while the previous result is still pending.
- ID wrap-around is modulo 2^IDSize.
- An enable_i change is only legal when idle; a mid-operation change is undefined but must recover after reset.
- fault_detected_o is registered, 1 cycle wide, and coincides with the faulty result's valid_o rising.

Optional Feature:
- Macro TIME_DMR_END_FAULT_CNT_EN.
- Defined: adds output fault_count_o (16 bit). It increments, saturating, on each fault_detected_o pulse and is reset to 0.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- enable=0, send 8'h11/tag 1 once, ready_i=1 -> data_o=same value in the same cycle, needs_retry_o=0.
- enable=1, send {data 0xA5, id 3} twice -> one output {0xA5, id 3}, needs_retry_o=0, 1 cycle after the 2nd beat; fault_detected_o=0.
- enable=1, copies 0xA5/0xA4 with id 3 -> output id 3, needs_retry_o=1, fault_detected_o pulses once.
- enable=1, id 3 then id 4 (copy lost) -> output id 3 with needs_retry_o=1; the id-4 beat pairs with the next id-4 beat -> output id 4 with needs_retry_o=0.
- enable=1, single copy id 5, next_id_i=6, no further beats -> after 48 cycles output id 5 with needs_retry_o=1; lock_o drops. With next_id_i=7: aborts the next cycle.
- enable=1, continuous duplicated stream, ready_i=1 for 1000 cycles -> at least 475 outputs, no retries; hold ready_i=0 -> outputs stable and ready_o=0 once a second result is pending.

Source files
------------

// File: rtl/time_dmr_end.sv
// Back end of a time-redundant (DMR) pipeline: pairs back-to-back copies, forwards one result per pair.
// Optional macro TIME_DMR_END_FAULT_CNT_EN adds a saturating 16-bit fault_count_o output.
module time_dmr_end #(
  parameter type         DataType           = logic [15:0],
  parameter int unsigned IDSize             = 4,
  parameter int unsigned LockTimeout        = 48,
  parameter bit          InternalRedundancy = 1'b0
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              enable_i,
  input  logic [IDSize-1:0] next_id_i,
  input  DataType           data_i,
  input  logic [IDSize-1:0] id_i,
  input  logic              valid_i,
  output logic              ready_o,
  output DataType           data_o,
  output logic [IDSize-1:0] id_o,
  output logic              needs_retry_o,
  output logic              valid_o,
  input  logic              ready_i,
  output logic              lock_o,
  output logic              fault_detected_o
`ifdef TIME_DMR_END_FAULT_CNT_EN
  ,
  output logic [15:0]       fault_count_o
`endif
);

  localparam int unsigned     CntW       = $clog2(LockTimeout + 1);
  localparam logic [CntW-1:0] TimeoutVal = CntW'(LockTimeout);

  typedef enum logic {
    EMPTY      = 1'b0,
    HAVE_FIRST = 1'b1
  } state_e;

  state_e            state_d, state_q;
  logic [CntW-1:0]   cnt_d, cnt_q;

  DataType           buf_data_d, buf_data_q;
  logic [IDSize-1:0] buf_id_d, buf_id_q;

  DataType           out_data_d, out_data_q;
  logic [IDSize-1:0] out_id_d, out_id_q;
  logic              out_retry_d, out_retry_q;
  logic              out_valid_d, out_valid_q;
  logic              fault_d, fault_q;

  logic              out_free;
  logic [IDSize-1:0] id_plus_one;

  assign out_free    = !out_valid_q || ready_i;
  assign id_plus_one = buf_id_q + IDSize'(1);

  // State and timeout counter; optionally kept in three voted copies.
  generate
    if (InternalRedundancy) begin : gen_tmr
      state_e          state_r_q [3];
      logic [CntW-1:0] cnt_r_q   [3];

      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          for (int i = 0; i < 3; i++) begin
            state_r_q[i] <= EMPTY;
            cnt_r_q[i]   <= '0;
          end
        end else begin
          for (int i = 0; i < 3; i++) begin
            state_r_q[i] <= state_d;
            cnt_r_q[i]   <= cnt_d;
          end
        end
      end

      assign state_q = state_e'((state_r_q[0] & state_r_q[1]) |
                                (state_r_q[0] & state_r_q[2]) |
                                (state_r_q[1] & state_r_q[2]));
      assign cnt_q   = (cnt_r_q[0] & cnt_r_q[1]) |
                       (cnt_r_q[0] & cnt_r_q[2]) |
                       (cnt_r_q[1] & cnt_r_q[2]);
    end else begin : gen_single
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          state_q <= EMPTY;
          cnt_q   <= '0;
        end else begin
          state_q <= state_d;
          cnt_q   <= cnt_d;
        end
      end
    end
  endgenerate

  // A handshake in HAVE_FIRST always wins over a pending timeout abort.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    buf_data_d  = buf_data_q;
    buf_id_d    = buf_id_q;
    out_data_d  = out_data_q;
    out_id_d    = out_id_q;
    out_retry_d = out_retry_q;
    out_valid_d = out_valid_q && !ready_i;
    fault_d     = 1'b0;

    if (!enable_i) begin
      state_d     = EMPTY;
      cnt_d       = '0;
      out_valid_d = 1'b0;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (valid_i) begin
            buf_data_d = data_i;
            buf_id_d   = id_i;
            cnt_d      = '0;
            state_d    = HAVE_FIRST;
          end
        end
        HAVE_FIRST: begin
          if (valid_i && out_free) begin
            out_valid_d = 1'b1;
            out_data_d  = buf_data_q;
            out_id_d    = buf_id_q;
            out_retry_d = (id_i != buf_id_q) || (data_i != buf_data_q);
            fault_d     = out_retry_d;
            if (id_i == buf_id_q) begin
              state_d = EMPTY;
            end else begin
              // Lost or duplicated copy: the new beat restarts pairing.
              buf_data_d = data_i;
              buf_id_d   = id_i;
              cnt_d      = '0;
            end
          end else if (cnt_q >= TimeoutVal) begin
            if (out_free) begin
              out_valid_d = 1'b1;
              out_data_d  = buf_data_q;
              out_id_d    = buf_id_q;
              out_retry_d = 1'b1;
              fault_d     = 1'b1;
              state_d     = EMPTY;
            end
          end else if (next_id_i != id_plus_one) begin
            cnt_d = TimeoutVal;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      buf_data_q  <= '0;
      buf_id_q    <= '0;
      out_data_q  <= '0;
      out_id_q    <= '0;
      out_retry_q <= 1'b0;
      out_valid_q <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      buf_data_q  <= buf_data_d;
      buf_id_q    <= buf_id_d;
      out_data_q  <= out_data_d;
      out_id_q    <= out_id_d;
      out_retry_q <= out_retry_d;
      out_valid_q <= out_valid_d;
      fault_q     <= fault_d;
    end
  end

  // Disabled mode is a pure wire-through of the handshake.
  always_comb begin
    if (enable_i) begin
      ready_o          = (state_q == EMPTY) ? 1'b1 : out_free;
      lock_o           = (state_q == HAVE_FIRST);
      data_o           = out_data_q;
      id_o             = out_id_q;
      needs_retry_o    = out_retry_q;
      valid_o          = out_valid_q;
      fault_detected_o = fault_q;
    end else begin
      ready_o          = ready_i;
      lock_o           = 1'b0;
      data_o           = data_i;
      id_o             = id_i;
      needs_retry_o    = 1'b0;
      valid_o          = valid_i;
      fault_detected_o = 1'b0;
    end
  end

`ifdef TIME_DMR_END_FAULT_CNT_EN
  logic [15:0] fault_cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fault_cnt_q <= '0;
    end else if (fault_detected_o && (fault_cnt_q != 16'hFFFF)) begin
      fault_cnt_q <= fault_cnt_q + 16'd1;
    end
  end

  assign fault_count_o = fault_cnt_q;
`endif

endmodule

// File: tb/tb_time_dmr_end.sv
// Self-checking bench for time_dmr_end: directed scenarios plus randomized duplicated streams
// checked against a transaction-level pairing model.
module tb_time_dmr_end;

  localparam int LockTimeout = 48;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        enable_i;
  logic [3:0]  next_id_i;
  logic [15:0] data_i;
  logic [3:0]  id_i;
  logic        valid_i;
  logic        ready_o;
  logic [15:0] data_o;
  logic [3:0]  id_o;
  logic        needs_retry_o;
  logic        valid_o;
  logic        ready_i;
  logic        lock_o;
  logic        fault_detected_o;
`ifdef TIME_DMR_END_FAULT_CNT_EN
  logic [15:0] faultCount;
`endif

  typedef struct packed {
    logic [15:0] data;
    logic [3:0]  id;
  } beat_t;

  typedef struct packed {
    logic [15:0] data;
    logic [3:0]  id;
    logic        retry;
  } res_t;

  int    testsRun = 0;
  int    testsFailed = 0;
  beat_t sched[$];
  res_t  expQ[$];
  int    schedIdx;
  bit    holding;
  beat_t pend;
  bit    pendValid;
  logic [3:0] lastId;
  int    outCount, retryOut, faultPulses, expRetries, totalExpFaults;
  int    waitN;

  always #5 clk_i = ~clk_i;

  time_dmr_end dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .enable_i         (enable_i),
    .next_id_i        (next_id_i),
    .data_i           (data_i),
    .id_i             (id_i),
    .valid_i          (valid_i),
    .ready_o          (ready_o),
    .data_o           (data_o),
    .id_o             (id_o),
    .needs_retry_o    (needs_retry_o),
    .valid_o          (valid_o),
    .ready_i          (ready_i),
    .lock_o           (lock_o),
`ifdef TIME_DMR_END_FAULT_CNT_EN
    .fault_count_o    (faultCount),
`endif
    .fault_detected_o (fault_detected_o)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    testsRun++;
    assert (obs === expv) else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Drive one cycle of inputs away from the clock edge and let outputs settle.
  task automatic applyStimulus(input logic v, input logic [15:0] d, input logic [3:0] id,
                               input logic [3:0] nid, input logic rdy);
    @(negedge clk_i);
    valid_i   = v;
    data_i    = d;
    id_i      = id;
    next_id_i = nid;
    ready_i   = rdy;
    #1;
  endtask

  // Reference pairing: first copy waits; second copy either matches it or flags a retry.
  function automatic void modelAccept(input beat_t b);
    res_t e;
    if (!pendValid) begin
      pend      = b;
      pendValid = 1'b1;
    end else begin
      e.data  = pend.data;
      e.id    = pend.id;
      e.retry = (b.id != pend.id) || (b.data != pend.data);
      expQ.push_back(e);
      if (e.retry) begin
        expRetries++;
        totalExpFaults++;
      end
      if (b.id == pend.id) pendValid = 1'b0;
      else pend = b;
    end
  endfunction

  task automatic resetModel();
    expQ.delete();
    sched.delete();
    pendValid   = 1'b0;
    schedIdx    = 0;
    holding     = 1'b0;
    outCount    = 0;
    retryOut    = 0;
    faultPulses = 0;
    expRetries  = 0;
    lastId      = 4'd0;
  endtask

  task automatic buildSched(input int nItems, input bit withFaults);
    beat_t b, c;
    int mode;
    logic [3:0] id;
    id = 4'($urandom_range(15));
    for (int k = 0; k < nItems; k++) begin
      b.data = 16'($urandom);
      b.id   = id;
      mode   = (withFaults && k != nItems - 1) ? int'($urandom_range(9)) : 9;
      sched.push_back(b);
      if (mode == 0) begin
        c = b;
        c.data = c.data ^ (16'd1 << $urandom_range(15));
        sched.push_back(c);
      end else if (mode != 1) begin
        sched.push_back(b);
      end
      id = id + 4'd1;
    end
  endtask

  task automatic runStream(input int maxCycles, input int readyPct, input int gapPct, input bit stopWhenDone);
    for (int c = 0; c < maxCycles; c++) begin
      if (stopWhenDone && schedIdx == sched.size() && expQ.size() == 0) break;
      @(negedge clk_i);
      ready_i = ($urandom_range(99) < readyPct);
      if (!holding && schedIdx < sched.size() && $urandom_range(99) >= gapPct) holding = 1'b1;
      if (holding) begin
        valid_i = 1'b1;
        data_i  = sched[schedIdx].data;
        id_i    = sched[schedIdx].id;
      end else begin
        valid_i = 1'b0;
        data_i  = 16'($urandom);
        id_i    = 4'($urandom);
      end
      next_id_i = lastId + 4'd1;
      #1;
      if (valid_o) begin
        if (expQ.size() == 0) begin
          checkOutput("spurious_valid", valid_o, 1'b0);
        end else begin
          checkOutput("out_data", data_o, expQ[0].data);
          checkOutput("out_id", id_o, expQ[0].id);
          checkOutput("out_retry", needs_retry_o, expQ[0].retry);
          if (ready_i) begin
            outCount++;
            if (needs_retry_o) retryOut++;
            expQ.delete(0);
          end
        end
      end
      if (fault_detected_o) faultPulses++;
      if (valid_i && ready_o) begin
        modelAccept(sched[schedIdx]);
        lastId = sched[schedIdx].id;
        schedIdx++;
        holding = 1'b0;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_ni = 1'b1; enable_i = 1'b0; valid_i = 1'b0; ready_i = 1'b0;
    data_i = '0; id_i = '0; next_id_i = '0;
    totalExpFaults = 0;
    resetModel();
    #2 rst_ni = 1'b0;
    #1;
    checkOutput("rst_data_o", data_o, 16'h0);
    checkOutput("rst_valid_o", valid_o, 1'b0);
    checkOutput("rst_ready_o", ready_o, 1'b0);
    checkOutput("rst_lock_o", lock_o, 1'b0);
    checkOutput("rst_retry", needs_retry_o, 1'b0);
    checkOutput("rst_fault", fault_detected_o, 1'b0);
    enable_i = 1'b1;
    #1;
    checkOutput("rst_en_valid_o", valid_o, 1'b0);
    checkOutput("rst_en_lock_o", lock_o, 1'b0);
    checkOutput("rst_en_id_o", id_o, 4'h0);
    checkOutput("rst_en_fault", fault_detected_o, 1'b0);
    @(negedge clk_i);
    rst_ni   = 1'b1;
    enable_i = 1'b0;

    // Pass-through mode
    applyStimulus(1'b1, 16'h0011, 4'd1, 4'd0, 1'b1);
    checkOutput("pt_data", data_o, 16'h0011);
    checkOutput("pt_id", id_o, 4'd1);
    checkOutput("pt_valid", valid_o, 1'b1);
    checkOutput("pt_ready", ready_o, 1'b1);
    checkOutput("pt_retry", needs_retry_o, 1'b0);
    checkOutput("pt_lock", lock_o, 1'b0);
    for (int i = 0; i < 4; i++) begin
      logic [15:0] d;
      logic [3:0] id;
      logic v, r;
      d = 16'($urandom); id = 4'($urandom); v = 1'($urandom); r = 1'($urandom);
      applyStimulus(v, d, id, 4'd0, r);
      checkOutput("pt_rand_data", data_o, d);
      checkOutput("pt_rand_id", id_o, id);
      checkOutput("pt_rand_valid", valid_o, v);
      checkOutput("pt_rand_ready", ready_o, r);
      checkOutput("pt_rand_fault", fault_detected_o, 1'b0);
    end
    applyStimulus(1'b0, 16'h0, 4'd0, 4'd0, 1'b1);
    enable_i = 1'b1;
    #1;
    checkOutput("en_idle_valid", valid_o, 1'b0);
    checkOutput("en_idle_lock", lock_o, 1'b0);

    // Matching pair
    applyStimulus(1'b1, 16'h00A5, 4'd3, 4'd4, 1'b1);
    checkOutput("pair_ready1", ready_o, 1'b1);
    applyStimulus(1'b1, 16'h00A5, 4'd3, 4'd4, 1'b1);
    checkOutput("pair_lock", lock_o, 1'b1);
    checkOutput("pair_not_yet", valid_o, 1'b0);
    applyStimulus(1'b0, 16'h0, 4'd0, 4'd4, 1'b1);
    checkOutput("pair_valid", valid_o, 1'b1);
    checkOutput("pair_data", data_o, 16'h00A5);
    checkOutput("pair_id", id_o, 4'd3);
    checkOutput("pair_retry", needs_retry_o, 1'b0);
    checkOutput("pair_fault", fault_detected_o, 1'b0);
    checkOutput("pair_unlock", lock_o, 1'b0);

    // Data mismatch
    applyStimulus(1'b1, 16'h00A5, 4'd3, 4'd4, 1'b1);
    applyStimulus(1'b1, 16'h00A4, 4'd3, 4'd4, 1'b1);
    applyStimulus(1'b0, 16'h0, 4'd0, 4'd4, 1'b1);
    checkOutput("dmis_valid", valid_o, 1'b1);
    checkOutput("dmis_id", id_o, 4'd3);
    checkOutput("dmis_data", data_o, 16'h00A5);
    checkOutput("dmis_retry", needs_retry_o, 1'b1);
    checkOutput("dmis_fault", fault_detected_o, 1'b1);
    applyStimulus(1'b0, 16'h0, 4'd0, 4'd4, 1'b1);
    checkOutput("dmis_fault_once", fault_detected_o, 1'b0);
    checkOutput("dmis_cleared", valid_o, 1'b0);

    // Lost copy: id 3 then id 4 twice
    applyStimulus(1'b1, 16'h1234, 4'd3, 4'd4, 1'b1);
    applyStimulus(1'b1, 16'h5678, 4'd4, 4'd4, 1'b1);
    checkOutput("lost_lock", lock_o, 1'b1);
    applyStimulus(1'b1, 16'h5678, 4'd4, 4'd5, 1'b1);
    checkOutput("lost_id3", id_o, 4'd3);
    checkOutput("lost_data3", data_o, 16'h1234);
    checkOutput("lost_retry3", needs_retry_o, 1'b1);
    checkOutput("lost_fault3", fault_detected_o, 1'b1);
    applyStimulus(1'b0, 16'h0, 4'd0, 4'd5, 1'b1);
    checkOutput("lost_valid4", valid_o, 1'b1);
    checkOutput("lost_id4", id_o, 4'd4);
    checkOutput("lost_data4", data_o, 16'h5678);
    checkOutput("lost_retry4", needs_retry_o, 1'b0);
    checkOutput("lost_fault4", fault_detected_o, 1'b0);

    // Timeout with consistent next_id: result appears LockTimeout+1 edges after the handshake edge
    applyStimulus(1'b1, 16'h0BAD, 4'd5, 4'd6, 1'b1);
    checkOutput("to_ready", ready_o, 1'b1);
    for (waitN = 1; waitN <= 200; waitN++) begin
      applyStimulus(1'b0, 16'h0, 4'd0, 4'd6, 1'b1);
      if (valid_o) break;
    end
    checkOutput("to_latency", waitN, LockTimeout + 2);
    checkOutput("to_id", id_o, 4'd5);
    checkOutput("to_data", data_o, 16'h0BAD);
    checkOutput("to_retry", needs_retry_o, 1'b1);
    checkOutput("to_fault", fault_detected_o, 1'b1);
    checkOutput("to_unlock", lock_o, 1'b0);
    applyStimulus(1'b0, 16'h0, 4'd0, 4'd6, 1'b1);
    checkOutput("to_cleared", valid_o, 1'b0);

    // Front end moved on: abort on the following cycle
    applyStimulus(1'b1, 16'h0C0D, 4'd5, 4'd7, 1'b1);
    for (waitN = 1; waitN <= 200; waitN++) begin
      applyStimulus(1'b0, 16'h0, 4'd0, 4'd7, 1'b1);
      if (valid_o) break;
    end
    checkOutput("fast_to_latency", waitN, 3);
    checkOutput("fast_to_id", id_o, 4'd5);
    checkOutput("fast_to_retry", needs_retry_o, 1'b1);
    checkOutput("fast_to_unlock", lock_o, 1'b0);

    // Reset in the middle of a pair must recover
    applyStimulus(1'b1, 16'h7777, 4'd9, 4'd10, 1'b1);
    @(negedge clk_i);
    valid_i = 1'b0;
    rst_ni  = 1'b0;
    #1;
    checkOutput("mid_rst_lock", lock_o, 1'b0);
    checkOutput("mid_rst_valid", valid_o, 1'b0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    totalExpFaults = 0;

    // Continuous duplicated stream at full downstream rate
    resetModel();
    buildSched(600, 1'b0);
    runStream(1000, 100, 0, 1'b0);
    checkOutput("thru_ge475", (outCount >= 475), 1'b1);
    checkOutput("thru_no_retry", retryOut, 0);
    runStream(8, 0, 0, 1'b0);
    checkOutput("stall_ready_o", ready_o, 1'b0);
    checkOutput("stall_valid_o", valid_o, 1'b1);
    runStream(2000, 100, 0, 1'b1);
    checkOutput("thru_drained", (expQ.size() == 0 && schedIdx == sched.size()), 1'b1);
    checkOutput("thru_faults", faultPulses, expRetries);
    checkOutput("thru_unlock", lock_o, 1'b0);

    // Randomized stream with corrupted and lost copies, gaps and backpressure
    resetModel();
    buildSched(200, 1'b1);
    runStream(4000, 70, 30, 1'b1);
    checkOutput("rand_drained", (expQ.size() == 0 && schedIdx == sched.size()), 1'b1);
    checkOutput("rand_fault_pulses", faultPulses, expRetries);
    checkOutput("rand_retry_outputs", retryOut, expRetries);
    checkOutput("rand_unlock", lock_o, 1'b0);
`ifdef TIME_DMR_END_FAULT_CNT_EN
    checkOutput("fault_count", faultCount, totalExpFaults);
`endif

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
